// File: rtl/mon_prod_param.sv
// Radix-2 Montgomery product engine: P = X*Y*2^-n mod M, operands fetched
// word-by-word from BRAM, result written back word-by-word.
module mon_prod_param #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned DBITS = 512,
    parameter int unsigned ABITS = 8,
    parameter int unsigned CBITS = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op_code,
    input  logic [ABITS-1:0] x_base,
    input  logic [ABITS-1:0] y_base,
    input  logic [ABITS-1:0] p_base,
    input  logic [WIDTH-1:0] M,
    input  logic [CBITS-1:0] n_bits,
    output logic [ABITS-1:0] rd_addr,
    input  logic [DBITS-1:0] rd_data,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             wr_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] P
);

    localparam int unsigned WORDS = WIDTH / DBITS;
    localparam int unsigned SW    = WIDTH + 2;

    localparam logic [1:0] OpXX = 2'd0;
    localparam logic [1:0] OpXM = 2'd1;

    // StReject spends one busy cycle so that an illegal request pulses done at e0+1.
    typedef enum logic [2:0] {
        StIdle, StLoadX, StLoadY, StMult, StReduce, StStore, StReject, StDone
    } state_e;

    state_e state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [ABITS-1:0] y_base_q, y_base_d;
    logic [ABITS-1:0] p_base_q, p_base_d;
    logic [ABITS-1:0] rd_addr_q, rd_addr_d;
    logic [ABITS-1:0] wr_addr_q, wr_addr_d;
    logic [DBITS-1:0] wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             err_q, err_d;
    logic [CBITS-1:0] n_q, n_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] p_q, p_d;
    // Accumulator during MULT/REDUCE; reused as the output shift register in STORE.
    logic [SW-1:0]    s_q, s_d;

    logic             req_illegal;
    logic [WIDTH-1:0] rd_ext;
    logic [WIDTH-1:0] x_shift;
    logic [WIDTH-1:0] y_shift;
    logic [SW:0]      t_a;
    logic [SW:0]      t_b;
    logic [SW-1:0]    s_mult;
    logic [SW-1:0]    m_ext;
    logic [SW-1:0]    s_red;

    assign req_illegal = (op_code == 2'd3) || (n_bits == '0) || (32'(n_bits) > WIDTH);

    // Word assembly, Montgomery step and final subtraction datapath.
    always_comb begin
        rd_ext              = '0;
        rd_ext[DBITS-1:0]   = rd_data;
        // Words arrive low first, so each new word enters at the top and shifts down.
        x_shift = (x_q >> DBITS) | (rd_ext << (WIDTH - DBITS));
        y_shift = (y_q >> DBITS) | (rd_ext << (WIDTH - DBITS));
        t_a     = {1'b0, s_q} + (x_q[0] ? {3'b000, y_q} : '0);
        t_b     = t_a + (t_a[0] ? {3'b000, m_q} : '0);
        s_mult  = SW'(t_b >> 1);
        m_ext   = {2'b00, m_q};
        s_red   = (s_q >= m_ext) ? (s_q - m_ext) : s_q;
    end

    // Next-state and next-value logic for the whole engine.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        y_base_d  = y_base_q;
        p_base_d  = p_base_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        err_d     = err_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        x_d       = x_q;
        y_d       = y_q;
        p_d       = p_q;
        s_d       = s_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d     = op_code;
                    y_base_d = y_base;
                    p_base_d = p_base;
                    n_d      = n_bits;
                    m_d      = M;
                    cnt_d    = '0;
                    s_d      = '0;
                    if (req_illegal) begin
                        err_d   = 1'b1;
                        state_d = StReject;
                    end else begin
                        err_d     = 1'b0;
                        rd_addr_d = x_base;
                        state_d   = StLoadX;
                    end
                end
            end
            StLoadX: begin
                rd_addr_d = rd_addr_q + 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q != '0) begin
                    x_d = x_shift;
                end
                if (cnt_q == CBITS'(WORDS)) begin
                    cnt_d = '0;
                    if (op_q == OpXM) begin
                        rd_addr_d = y_base_q;
                        state_d   = StLoadY;
                    end else begin
                        y_d     = (op_q == OpXX) ? x_shift : WIDTH'(1);
                        state_d = StMult;
                    end
                end
            end
            StLoadY: begin
                rd_addr_d = rd_addr_q + 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q != '0) begin
                    y_d = y_shift;
                end
                if (cnt_q == CBITS'(WORDS)) begin
                    cnt_d   = '0;
                    state_d = StMult;
                end
            end
            StMult: begin
                s_d   = s_mult;
                x_d   = x_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == n_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                p_d       = s_red[WIDTH-1:0];
                wr_data_d = s_red[DBITS-1:0];
                s_d       = s_red >> DBITS;
                wr_addr_d = p_base_q;
                wr_en_d   = 1'b1;
                cnt_d     = '0;
                state_d   = StStore;
            end
            StStore: begin
                if (cnt_q == CBITS'(WORDS - 1)) begin
                    state_d = StDone;
                end else begin
                    wr_data_d = s_q[DBITS-1:0];
                    s_d       = s_q >> DBITS;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_en_d   = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            StReject: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered BRAM/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            y_base_q  <= '0;
            p_base_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            n_q       <= '0;
            cnt_q     <= '0;
            m_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            p_q       <= '0;
            s_q       <= '0;
        end else begin
            op_q      <= op_d;
            y_base_q  <= y_base_d;
            p_base_q  <= p_base_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            x_q       <= x_d;
            y_q       <= y_d;
            p_q       <= p_d;
            s_q       <= s_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_en   = wr_en_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign err     = (state_q == StDone) && err_q;
    assign P       = p_q;

endmodule

// File: doc/mon_prod_param.md
# mon_prod_param

Parametrised radix-2 Montgomery product engine, successor to `mon_prod`. It fetches operands word-by-word from the shared BRAM read port. It computes P = X·Y·2^-n mod M for a run-time iteration count n, applies the final conditional subtraction so that P < M, and writes P back to BRAM. It sits between the modular-exponentiation sequencer, which drives `start` and `op_code`, and `bram` (write port 1 / read port).

## Interface
- `WIDTH`, 1024: operand/modulus width in bits.
- `DBITS`, 512: BRAM data width. `WIDTH % DBITS == 0` is required. `WORDS = WIDTH/DBITS`.
- `ABITS`, 8: BRAM address width.
- `CBITS`, 11: width of `n_bits`. Must hold the value WIDTH.

Ports:
- `clk` in 1: clock. All logic is on the posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `op_code` in 2: 0 OPXX (Y=X), 1 OPXM (Y from BRAM), 2 OPX1 (Y=1), 3 illegal.
- `x_base`, `y_base`, `p_base` in ABITS: word base addresses of X, Y and the result.
- `M` in WIDTH: odd modulus. Held stable while `busy`.
- `n_bits` in CBITS: iteration count n, valid range 1..WIDTH.
- `rd_addr` out ABITS: BRAM read address.
- `rd_data` in DBITS: BRAM read data. Read latency is one cycle.
- `wr_addr` out ABITS, `wr_data` out DBITS, `wr_en` out 1: BRAM write port. All are registered.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE state.
- `done` out 1: one-cycle pulse.
- `err` out 1: one-cycle pulse, coincident with `done`, on an illegal request.
- `P` out WIDTH: result register. Holds its value until the next successful STORE.

## Operation
- States: IDLE → LOAD_X → [LOAD_Y] → MULT → REDUCE → STORE → DONE → IDLE.
- **IDLE**
  - `start`=1 with a legal request moves the FSM to LOAD_X. All inputs are latched in this cycle.
  - A request is illegal if `op_code`=3, `n_bits`=0, or `n_bits`>WIDTH. An illegal request goes directly to DONE with `err`=1. There are no BRAM accesses and `P` is unchanged.
- **LOAD_X** (WORDS+1 cycles)
  - Reads addresses x_base+i for i = 0..WORDS-1, least-significant word first.
  - Word i is captured one cycle after its address is presented.
- **LOAD_Y** (WORDS+1 cycles)
  - OPXM only, same scheme as LOAD_X using y_base.
  - OPXX sets Y=X and OPX1 sets Y=1, with zero cycles spent in this state.
- **MULT** (n_bits cycles)
  - Uses a (WIDTH+2)-bit accumulator S, initialised to 0.
  - Each cycle: t = S + x0·Y; q = t[0]; S ← (t + q·M) >> 1; X ← X >> 1.
  - No truncation is allowed.
- **REDUCE** (1 cycle): if S ≥ M then S ← S − M. The result is latched into `P`.
- **STORE** (WORDS cycles)
  - Writes word i of P to p_base+i, low word first, one word per cycle with `wr_en`=1.
- **DONE** (1 cycle): `done`=1, then return to IDLE.
- Address arithmetic is modulo 2^ABITS. A base+i that exceeds the range wraps around silently.
- Preconditions: X < M, Y < M, M < 2^n_bits. Under these, S < 2M before REDUCE, so P < M.
- `start` is ignored while `busy` or in DONE. It is not queued.
- `rst`
  - Takes effect at the next edge from any state: the FSM goes to IDLE, and `busy`, `done`, `err`, `wr_en`, `rd_addr`, `wr_addr`, `wr_data` and `P` are cleared to 0.
  - An aborted operation writes nothing further.
  - No BRAM write is issued in the cycle after `rst` is sampled.

## Timing
- Edge e0 is the edge that samples `start`. `done` rises at e0+L.
- L = (WORDS+1) + (WORDS+1 if OPXM, else 0) + n_bits + 1 + WORDS. `done` falls one edge later.
- For an illegal request, `done` and `err` rise at e0+1.
- `busy` rises at e0 and falls when `done` falls.
- A new `start` can be accepted at the first IDLE cycle, so back-to-back operations are separated by one idle cycle.
- `rd_addr` is don't-care outside the LOAD states. `wr_en` is 0 outside STORE.
- Reset values: all outputs 0; the FSM is in IDLE.

## Test plan
- **OPXM, X vs Y:**
  - Setup: WIDTH=1024, DBITS=512, X=435 @0..1, Y=535 @2..3, M=589, n=10, p_base=4.
  - Expected: P=535; words 535 then 0 written to addresses 4 and 5; `done` at e0+19.
- **OPXX and OPX1:**
  - Setup: X=435, M=589, n=10.
  - Expected: OPXX gives P=435 with `done` at e0+16. OPX1 gives P=1.
- **Final subtraction:**
  - Setup: X=Y=12, M=13, n=4, OPXM.
  - Expected: P=9, and P < M for randomised X,Y < M checked against a reference model.
- **Illegal requests:**
  - Setup: `op_code`=3, and separately n_bits=0.
  - Expected: `done`=`err`=1 at e0+1; `wr_en` never asserts; `P` unchanged.
- **Reset mid-operation:**
  - Setup: assert `rst` during MULT, then again on the first STORE cycle.
  - Expected: no further `wr_en` pulses; all outputs 0 next cycle; a subsequent OPXM run produces P=535.
- **Start while busy:**
  - Setup: pulse `start` with different operands during LOAD_Y and during MULT.
  - Expected: ignored; first result intact; exactly one `done` per accepted request.
